ct_ifu_btb_upd_queue: RTL and testbench

Receives main-BTB mispredict update requests from the IFU address generator (index, tag, 20-bit target) and buffers them in a small FIFO. It drains them into the single-ported BTB SRAM write port in cycles when the BTB read pipeline does not own the array. It sits between the IB-stage address generator and the BTB array. It merges duplicate updates and reports dropped updates to the performance counters.

---
 rtl/ct_ifu_btb_upd_queue.sv | 185 ++++++++++++++++++
 tb/tb_ct_ifu_btb_upd_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_btb_upd_queue.sv
// ct_ifu_btb_upd_queue: buffers main-BTB mispredict updates from the IB-stage
// address generator and drains them into the single-ported BTB SRAM write
// port whenever the BTB read pipeline leaves the array idle.
// Optional feature macro: IFU_BTB_UPD_MERGE_EN (duplicate {index, tag} updates
// overwrite the queued target instead of taking a new slot).
// Write handshake: btbupd_btb_wen is a one-cycle strobe; the SRAM accepts it
// unconditionally, and a read request (pcgen_btb_rd_req) holds it low, so a
// write only ever happens in a cycle where rd_req is low.

// Latch-based clock gate; the enable is captured while the clock is low so the
// gated clock cannot glitch.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en && (module_en || local_en)) || external_en;

    // Transparent while the clock is low, holds during the high phase.
    always_latch begin
        if (!clk_in) clk_en_lat <= clk_en_bf_latch;
    end

    assign clk_out = clk_in && (clk_en_lat || pad_yy_icg_scan_en);
endmodule

module ct_ifu_btb_upd_queue #(
    parameter int DEPTH = 4
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_ifu_icg_en,
    input  logic        cp0_yy_clk_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic        addrgen_btb_update_vld,
    input  logic [9:0]  addrgen_btb_index,
    input  logic [9:0]  addrgen_btb_tag,
    input  logic [19:0] addrgen_btb_target_pc,
    input  logic        pcgen_btb_rd_req,
    input  logic        cp0_ifu_btb_inv,
    output logic        btbupd_btb_wen,
    output logic [9:0]  btbupd_btb_windex,
    output logic [9:0]  btbupd_btb_wtag,
    output logic [19:0] btbupd_btb_wtarget,
    output logic [1:0]  btbupd_btb_wway,
    output logic        btbupd_ifctrl_busy,
    output logic        btbupd_hpcp_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [9:0]     idx_q [DEPTH];
    logic [9:0]     idx_d [DEPTH];
    logic [9:0]     tag_q [DEPTH];
    logic [9:0]     tag_d [DEPTH];
    logic [19:0]    tgt_q [DEPTH];
    logic [19:0]    tgt_d [DEPTH];
    logic [1:0]     way_q, way_d;

    logic           empty, full, deq, enq, merge, drop;
    logic [AW-1:0]  rd_idx, wr_idx, merge_ptr;
    logic           head_vld;
    logic           local_en;
    logic           upd_clk;

    assign rd_idx = rptr_q[AW-1:0];
    assign wr_idx = wptr_q[AW-1:0];

    // The wrap bit distinguishes full from empty when the low bits coincide.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Read pipeline owns the array whenever it asks; invalidate also blocks writes.
    assign deq = !empty && !pcgen_btb_rd_req && !cp0_ifu_btb_inv;

`ifdef IFU_BTB_UPD_MERGE_EN
    // Find a live entry with the same {index, tag}; the head leaving this cycle is excluded.
    always_comb begin
        merge     = 1'b0;
        merge_ptr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (idx_q[i] == addrgen_btb_index) && (tag_q[i] == addrgen_btb_tag)
                && !(deq && (AW'(i) == rd_idx))) begin
                merge     = addrgen_btb_update_vld;
                merge_ptr = AW'(i);
            end
        end
    end
`else
    assign merge     = 1'b0;
    assign merge_ptr = '0;
`endif

    // A dequeue in the same cycle never frees a slot for the incoming request.
    assign enq  = addrgen_btb_update_vld && !merge && !full && !cp0_ifu_btb_inv;
    assign drop = addrgen_btb_update_vld && !merge &&  full && !cp0_ifu_btb_inv;

    assign local_en = addrgen_btb_update_vld || deq || cp0_ifu_btb_inv;

    gated_clk_cell x_upd_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (upd_clk)
    );

    // Next-state for pointers, valid bits, payload and way counter.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        vld_d  = vld_q;
        idx_d  = idx_q;
        tag_d  = tag_q;
        tgt_d  = tgt_q;
        way_d  = way_q;
        if (cp0_ifu_btb_inv) begin
            wptr_d = '0;
            rptr_d = '0;
            vld_d  = '0;
            way_d  = 2'd0;
        end else begin
            if (deq) begin
                vld_d[rd_idx] = 1'b0;
                rptr_d        = rptr_q + 1'b1;
                way_d         = way_q + 2'd1;
            end
            if (merge) begin
                tgt_d[merge_ptr] = addrgen_btb_target_pc;
            end
            if (enq) begin
                vld_d[wr_idx] = 1'b1;
                idx_d[wr_idx] = addrgen_btb_index;
                tag_d[wr_idx] = addrgen_btb_tag;
                tgt_d[wr_idx] = addrgen_btb_target_pc;
                wptr_d        = wptr_q + 1'b1;
            end
        end
    end

    // All queue state lives on the gated clock; reset clears everything.
    always_ff @(posedge upd_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
            way_q  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            vld_q  <= vld_d;
            way_q  <= way_d;
            idx_q  <= idx_d;
            tag_q  <= tag_d;
            tgt_q  <= tgt_d;
        end
    end

    // Head fields are shown only while the head slot holds a live entry.
    assign head_vld           = vld_q[rd_idx];
    assign btbupd_btb_wen     = deq;
    assign btbupd_btb_windex  = head_vld ? idx_q[rd_idx] : 10'd0;
    assign btbupd_btb_wtag    = head_vld ? tag_q[rd_idx] : 10'd0;
    assign btbupd_btb_wtarget = head_vld ? tgt_q[rd_idx] : 20'd0;
    assign btbupd_btb_wway    = way_q;
    assign btbupd_ifctrl_busy = !empty;
    assign btbupd_hpcp_drop   = drop;
endmodule

// File: tb/tb_ct_ifu_btb_upd_queue.sv
// Bench for ct_ifu_btb_upd_queue: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_ct_ifu_btb_upd_queue;
  localparam int DEPTH = 4;
`ifdef IFU_BTB_UPD_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        upd_vld;
  logic [9:0]  upd_idx;
  logic [9:0]  upd_tag;
  logic [19:0] upd_tgt;
  logic        rd_req;
  logic        inv;
  logic        wen;
  logic [9:0]  windex;
  logic [9:0]  wtag;
  logic [19:0] wtarget;
  logic [1:0]  wway;
  logic        busy;
  logic        drop;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  // model state: queue of {index, tag, target}, plus way counter
  logic [39:0] exp_q[$];
  int          m_way = 0;

  typedef struct {
    logic        u;
    logic [9:0]  i;
    logic [9:0]  t;
    logic [19:0] g;
    logic        rd;
    logic        iv;
    logic        e_wen;
    logic [9:0]  e_idx;
    logic [9:0]  e_tag;
    logic [19:0] e_tgt;
    logic [1:0]  e_way;
    logic        e_busy;
    logic        e_drop;
  } vec_t;
  vec_t vecs[$];

  ct_ifu_btb_upd_queue #(.DEPTH(DEPTH)) dut (
    .forever_cpuclk         (clk),
    .cpurst_b               (cpurst_b),
    .cp0_ifu_icg_en         (1'b0),
    .cp0_yy_clk_en          (1'b1),
    .pad_yy_icg_scan_en     (1'b0),
    .addrgen_btb_update_vld (upd_vld),
    .addrgen_btb_index      (upd_idx),
    .addrgen_btb_tag        (upd_tag),
    .addrgen_btb_target_pc  (upd_tgt),
    .pcgen_btb_rd_req       (rd_req),
    .cp0_ifu_btb_inv        (inv),
    .btbupd_btb_wen         (wen),
    .btbupd_btb_windex      (windex),
    .btbupd_btb_wtag        (wtag),
    .btbupd_btb_wtarget     (wtarget),
    .btbupd_btb_wway        (wway),
    .btbupd_ifctrl_busy     (busy),
    .btbupd_hpcp_drop       (drop)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic u, input logic [9:0] i, input logic [9:0] t,
                              input logic [19:0] g, input logic rd, input logic iv,
                              input logic ew, input logic [9:0] ei, input logic [9:0] et,
                              input logic [19:0] eg, input logic [1:0] ey,
                              input logic eb, input logic ed);
    vec_t v;
    v.u = u; v.i = i; v.t = t; v.g = g; v.rd = rd; v.iv = iv;
    v.e_wen = ew; v.e_idx = ei; v.e_tag = et; v.e_tgt = eg; v.e_way = ey;
    v.e_busy = eb; v.e_drop = ed;
    return v;
  endfunction

  // One clock cycle: drive at negedge, check against the model, advance the model.
  task automatic step(input logic u, input logic [9:0] i, input logic [9:0] t,
                      input logic [19:0] g, input logic rd, input logic iv);
    int n;
    int hit;
    int start;
    logic e_wen;
    logic e_busy;
    logic e_drop;
    logic acc;
    logic [39:0] h;
    @(negedge clk);
    upd_vld = u; upd_idx = i; upd_tag = t; upd_tgt = g; rd_req = rd; inv = iv;
    #2;
    n      = exp_q.size();
    e_wen  = !iv && !rd && (n > 0);
    e_busy = (n > 0);
    hit    = -1;
    start  = e_wen ? 1 : 0;
    if (MERGE && u && !iv) begin
      for (int k = start; k < n; k++)
        if (exp_q[k][39:20] == {i, t}) hit = k;
    end
    e_drop = u && !iv && (hit < 0) && (n == DEPTH);
    acc    = u && !iv && (hit < 0) && (n < DEPTH);
    chk("model_wen", wen, e_wen);
    chk("model_busy", busy, e_busy);
    chk("model_drop", drop, e_drop);
    chk("model_wway", wway, 32'(m_way));
    if (e_wen) begin
      h = exp_q[0];
      chk("model_windex", windex, h[39:30]);
      chk("model_wtag", wtag, h[29:20]);
      chk("model_wtarget", wtarget, h[19:0]);
    end
    if (wen) wr_cnt++;
    if (iv) begin
      exp_q.delete();
      m_way = 0;
    end else begin
      if (hit >= 0) begin
        h = exp_q[hit];
        h[19:0] = g;
        exp_q[hit] = h;
      end
      if (e_wen) begin
        void'(exp_q.pop_front());
        m_way = (m_way + 1) % 4;
      end
      if (acc) exp_q.push_back({i, t, g});
    end
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 10'd0, 10'd0, 20'd0, rd, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_windex"}, windex, 0);
    chk({tag, "_wtag"}, wtag, 0);
    chk({tag, "_wtarget"}, wtarget, 0);
    chk({tag, "_wway"}, wway, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drop"}, drop, 0);
  endtask

  initial begin
    vec_t v;
    // reset
    cpurst_b = 1'b0;
    upd_vld = 1'b0; upd_idx = '0; upd_tag = '0; upd_tgt = '0; rd_req = 1'b0; inv = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    cpurst_b = 1'b1;

    // directed table: fill under a held read, drop the 5th, drain in order; then single update
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 10'h100 + 10'(k), 10'h200 + 10'(k), 20'h10000 + 20'(k), 1, 0,
                        0, 0, 0, 0, 0, (k != 0), 0));
    vecs.push_back(mk(1, 10'h3FF, 10'h3FF, 20'hFFFFF, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 10'h100 + 10'(k), 10'h200 + 10'(k),
                        20'h10000 + 20'(k), 2'(k), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 10'h155, 10'h2AA, 20'hABCDE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 10'h155, 10'h2AA, 20'hABCDE, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      step(v.u, v.i, v.t, v.g, v.rd, v.iv);
      chk("tbl_wen", wen, v.e_wen);
      chk("tbl_busy", busy, v.e_busy);
      chk("tbl_drop", drop, v.e_drop);
      chk("tbl_wway", wway, v.e_way);
      if (v.e_wen) begin
        chk("tbl_windex", windex, v.e_idx);
        chk("tbl_wtag", wtag, v.e_tag);
        chk("tbl_wtarget", wtarget, v.e_tgt);
      end
    end

    // full queue with a concurrent drain and a new update: update dropped, 3 remain
    for (int k = 0; k < 4; k++) step(1, 10'h010 + 10'(k), 10'h020, 20'h00300 + 20'(k), 1, 0);
    step(1, 10'h055, 10'h066, 20'h77777, 0, 0);
    chk("full_deq_drop", drop, 1);
    chk("full_deq_wen", wen, 1);
    wr_cnt = 0;
    repeat (5) idle(0);
    chk("full_deq_remaining", wr_cnt, 3);

    // duplicate update while the read pipeline holds the array
    step(1, 10'h0AA, 10'h0BB, 20'h11111, 1, 0);
    step(1, 10'h0CC, 10'h0DD, 20'h33333, 1, 0);
    step(1, 10'h0AA, 10'h0BB, 20'h22222, 1, 0);
    wr_cnt = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("merge_first_target", wtarget, MERGE ? 20'h22222 : 20'h11111);
    repeat (4) idle(0);
    chk("merge_write_count", wr_cnt, MERGE ? 2 : 3);

    // invalidate with 3 queued entries and a concurrent update
    step(1, 10'h001, 10'h002, 20'h00001, 1, 0);
    step(1, 10'h003, 10'h004, 20'h00002, 1, 0);
    step(1, 10'h005, 10'h006, 20'h00003, 1, 0);
    step(1, 10'h007, 10'h008, 20'h00004, 0, 1);
    chk("inv_wen", wen, 0);
    chk("inv_drop", drop, 0);
    idle(0);
    chk("inv_busy_after", busy, 0);
    chk("inv_wway_after", wway, 0);

    // reset in the middle of a drain
    step(1, 10'h101, 10'h102, 20'hAAAAA, 1, 0);
    step(1, 10'h103, 10'h104, 20'hBBBBB, 1, 0);
    step(1, 10'h105, 10'h106, 20'hCCCCC, 1, 0);
    idle(0);
    @(negedge clk);
    upd_vld = 1'b0; rd_req = 1'b0; inv = 1'b0;
    #1;
    chk("mid_drain_wen", wen, 1);
    cpurst_b = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    m_way = 0;
    @(negedge clk);
    cpurst_b = 1'b1;
    step(1, 10'h2F0, 10'h1E1, 20'h5A5A5, 0, 0);
    idle(0);
    chk("post_reset_wen", wen, 1);
    chk("post_reset_wway", wway, 0);
    chk("post_reset_wtarget", wtarget, 20'h5A5A5);

    // random traffic with a narrow key space so duplicates and full cases occur
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)), 10'($urandom_range(0, 1)),
           20'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
    end
    repeat (6) idle(0);
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
